// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue controller: opcodes, FSM states and default sizes.
package alu_issue_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NREG  = 8;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    LSL = 3'b001,
    LSR = 3'b010,
    XOR = 3'b011,
    SNE = 3'b100,
    SEQ = 3'b101,
    MSK = 3'b110,
    RSV = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

endpackage

// File: rtl/alu_issue_if.sv
// Bus between decoder/consumer/ALU and the issue controller; Trap exists only with ALU_ISSUE_TRAP_EN.
interface alu_issue_if import alu_issue_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREG  = DEFAULT_NREG
);
  localparam int IW = $clog2(NREG);

  logic             InstrValid;
  logic             InstrReady;
  logic [2:0]       InstrOp;
  logic [IW-1:0]    InstrRd;
  logic [IW-1:0]    InstrRs;
  logic             RegWrEn;
  logic [IW-1:0]    RegWrAddr;
  logic [WIDTH-1:0] RegWrData;
  logic [WIDTH-1:0] AluInputA;
  logic [WIDTH-1:0] AluInputB;
  logic [2:0]       AluOp;
  logic             AluScIn;
  logic [WIDTH-1:0] AluOut;
  logic             AluZero;
  logic             ResultValid;
  logic             ResultReady;
  logic [WIDTH-1:0] ResultData;
  logic             FlagZero;
`ifdef ALU_ISSUE_TRAP_EN
  logic             Trap;
`endif

  // Master is everything around the controller: decoder, result consumer and the ALU itself.
  modport master (
    output InstrValid, InstrOp, InstrRd, InstrRs, RegWrEn, RegWrAddr, RegWrData,
    output AluOut, AluZero, ResultReady,
    input  InstrReady, AluInputA, AluInputB, AluOp, AluScIn, ResultValid, ResultData, FlagZero
`ifdef ALU_ISSUE_TRAP_EN
    , input Trap
`endif
  );

  modport slave (
    input  InstrValid, InstrOp, InstrRd, InstrRs, RegWrEn, RegWrAddr, RegWrData,
    input  AluOut, AluZero, ResultReady,
    output InstrReady, AluInputA, AluInputB, AluOp, AluScIn, ResultValid, ResultData, FlagZero
`ifdef ALU_ISSUE_TRAP_EN
    , output Trap
`endif
  );

endinterface

// File: rtl/alu_issue_regfile.sv
// NREG x WIDTH register file: two asynchronous read ports, one write port, cleared by reset.
module alu_issue_regfile #(
  parameter int WIDTH = 8,
  parameter int NREG  = 8,
  parameter int IW    = $clog2(NREG)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr_a,
  input  logic [IW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [NREG];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues Rd = Rd op Rs to an external ALU and writes the result back (IDLE -> EXEC -> WB).
// Optional ALU_ISSUE_TRAP_EN: opcode RSV traps (sticky Trap, no writeback, issue blocked).
module alu_issue_ctrl import alu_issue_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREG  = DEFAULT_NREG
) (
  input logic       Clk,
  input logic       Reset,
  alu_issue_if.slave bus
);

  localparam int IW = $clog2(NREG);

  state_t           state;
  op_t              op_q;
  logic [IW-1:0]    rd_q;
  logic             sc_reg;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             accept;
  logic             blocked;
  logic             trap_op;
  logic             rf_we;
  logic [IW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

`ifdef ALU_ISSUE_TRAP_EN
  logic trap_q;
  assign blocked  = trap_q;
  assign trap_op  = (op_q == RSV);
  assign bus.Trap = trap_q;
`else
  assign blocked  = 1'b0;
  assign trap_op  = 1'b0;
`endif

  assign bus.InstrReady = (state == IDLE) && !blocked;
  assign accept         = bus.InstrReady && bus.InstrValid;

  // Writeback lands on the EXEC->WB edge straight from the ALU, so it happens exactly once.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = bus.RegWrAddr;
    rf_wdata = bus.RegWrData;
    if (state == EXEC && !trap_op) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = bus.AluOut;
    end else if (state == IDLE && bus.RegWrEn && !accept) begin
      rf_we    = 1'b1;
    end
  end

  alu_issue_regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
    .Clk     (Clk),
    .Reset   (Reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (bus.InstrRd),
    .raddr_b (bus.InstrRs),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // ALU drive is registered at the accepting edge so operands are stable for the whole EXEC cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state           <= IDLE;
      op_q            <= ADD;
      rd_q            <= '0;
      sc_reg          <= 1'b0;
      bus.AluInputA   <= '0;
      bus.AluInputB   <= '0;
      bus.AluOp       <= '0;
      bus.AluScIn     <= 1'b0;
      bus.ResultValid <= 1'b0;
      bus.ResultData  <= '0;
      bus.FlagZero    <= 1'b0;
`ifdef ALU_ISSUE_TRAP_EN
      trap_q          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q          <= op_t'(bus.InstrOp);
            rd_q          <= bus.InstrRd;
            bus.AluInputA <= rd_a;
            bus.AluInputB <= rd_b;
            bus.AluOp     <= bus.InstrOp;
            bus.AluScIn   <= (op_t'(bus.InstrOp) == LSL) ? sc_reg : 1'b0;
            state         <= EXEC;
          end
        end
        EXEC: begin
          if (trap_op) begin
`ifdef ALU_ISSUE_TRAP_EN
            trap_q <= 1'b1;
`endif
            bus.AluInputA <= '0;
            bus.AluInputB <= '0;
            bus.AluOp     <= '0;
            bus.AluScIn   <= 1'b0;
            state         <= IDLE;
          end else begin
            bus.ResultData  <= bus.AluOut;
            bus.FlagZero    <= bus.AluZero;
            bus.ResultValid <= 1'b1;
            if (op_q == LSL) sc_reg <= bus.AluInputA[WIDTH-1];
            if (op_q == LSR) sc_reg <= bus.AluInputA[0];
            state <= WB;
          end
        end
        WB: begin
          if (bus.ResultReady) begin
            bus.ResultValid <= 1'b0;
            bus.AluInputA   <= '0;
            bus.AluInputB   <= '0;
            bus.AluOp       <= '0;
            bus.AluScIn     <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
